hilo_divider: RTL and testbench
===============================

# hilo_divider

Parametrised multi-cycle iterative divider producing quotient and remainder for the CPU's HI/LO register pair (quotient → LO, remainder → HI). It serves both DIVU and DIV through a run-time signed/unsigned mode, works at any operand width, and uses a start/busy/done handshake so the control FSM can stall while it runs. It sits beside the ALU and is instantiated by the CPU datapath.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- abort  input  1  cancel an in-flight division; sampled only when busy=1.
- is_signed  input  1  1 = DIV semantics, 0 = DIVU; captured with start.
- dividend  input  WIDTH  rs operand; captured with start.
- divisor  input  WIDTH  rt operand; captured with start.
- busy  output  1  division in progress.
- done  output  1  one-cycle pulse: quotient/remainder just updated.
- quotient  output  WIDTH  result for LO.
- remainder  output  WIDTH  result for HI.
- div_zero  output  1  last completed division had divisor = 0; valid with and after done.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 captures operands and mode, converts signed operands to magnitudes, records result signs, loads the iteration counter with WIDTH, goes to CALC; busy=1 from the next cycle.
- CALC: one restoring-division step per cycle (shift remainder:quotient left 1, trial-subtract divisor magnitude, keep if non-negative, set quotient LSB); counter decrements; at 0 → FIX.
- FIX: negate quotient if dividend and divisor signs differ; negate remainder if dividend negative (truncating division, remainder takes dividend's sign); register quotient, remainder, div_zero; done=1; → IDLE.
- Divide by zero: no trap; quotient = all ones, remainder = dividend (original, unconverted); div_zero=1; normal latency.
- Signed overflow (most-negative / −1): quotient = most-negative value, remainder = 0; div_zero=0.
- Operand changes after the start cycle are ignored.
- start while busy=1 is ignored (not queued).
- abort while busy=1: → IDLE on the next edge, no done, quotient/remainder/div_zero keep previous values. abort in IDLE has no effect; start+abort together in IDLE starts a division.
- quotient, remainder, div_zero hold until the next done.

## Timing
- Reset (async, any state including mid-division): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, internal registers cleared.
- start accepted at edge E0 → busy=1 after E0; CALC steps at edges E1..EWIDTH; FIX at EWIDTH+1 → done=1 and results valid for the cycle after EWIDTH+1; busy=0 in that same cycle.
- Latency start-edge to done: WIDTH+1 cycles (33 for WIDTH=32), independent of operands.
- Back-to-back: start may be asserted in the done cycle; accepted at the next edge.
- Counter width: clog2(WIDTH+1). Internal partial remainder: WIDTH+1 bits to hold the subtract borrow.

## Configuration
- DIV_SIGNED_EN defined: is_signed honoured; magnitude conversion and FIX sign correction included.
- Not defined: is_signed ignored, every operation is unsigned; FIX state still present (copies results unchanged) so latency stays WIDTH+1 and the control FSM is identical in both builds.

## Test plan
- WIDTH=32, unsigned 100 / 7 → done at cycle 33 after start, quotient=14, remainder=2, div_zero=0.
- WIDTH=32, unsigned 0xE8BA0CDE / 0xFFFFEDCA → quotient=0x00000000, remainder=0xE8BA0CDE; also 0xFFFFFFFF / 0x10 → quotient=0x0FFFFFFF, remainder=0xF.
- WIDTH=32, signed (DIV_SIGNED_EN) −100 / 7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2); 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divisor 0, dividend 0x1234 → quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1; next valid divide clears div_zero.
- Start, then abort at cycle 10 → busy=0 next cycle, no done, outputs unchanged; start at cycle 12 ignored-while-busy check, then reset asserted mid-CALC → all outputs 0 immediately.
- WIDTH=8, unsigned 200 / 3 → done after 9 cycles, quotient=66, remainder=2; build without DIV_SIGNED_EN, is_signed=1, 0xFF / 0x02 → quotient=0x7F, remainder=1.

Source files
------------

// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider for the HI/LO pair: quotient -> LO, remainder -> HI.
// Define DIV_SIGNED_EN to honour is_signed (DIV); without it every operation is DIVU.
module hilo_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs_mag;
   logic [WIDTH-1:0] r_dvd_orig;
   logic             r_dvs_zero;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_zero;

   logic             w_load;
   logic             w_step;
   logic             w_fix;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

`ifdef DIV_SIGNED_EN
   logic r_q_neg;
   logic r_r_neg;
   logic w_dvd_neg;
   logic w_dvs_neg;

   // Operand magnitudes and result signs for DIV semantics.
   always_comb begin
      w_dvd_neg = is_signed & dividend[WIDTH-1];
      w_dvs_neg = is_signed & divisor[WIDTH-1];
      if (w_dvd_neg) begin
         w_dvd_mag = ~dividend + ONE;
      end else begin
         w_dvd_mag = dividend;
      end
      if (w_dvs_neg) begin
         w_dvs_mag = ~divisor + ONE;
      end else begin
         w_dvs_mag = divisor;
      end
   end

   // Sign latch; remainder follows the dividend so division truncates toward zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
      end else if (w_load) begin
         r_q_neg <= w_dvd_neg ^ w_dvs_neg;
         r_r_neg <= w_dvd_neg;
      end
   end

   // Sign correction applied in FIX; divide-by-zero overrides it.
   always_comb begin
      if (r_dvs_zero) begin
         w_quo_fix = ALL_ONES;
         w_rem_fix = r_dvd_orig;
      end else begin
         if (r_q_neg) begin
            w_quo_fix = ~r_quo + ONE;
         end else begin
            w_quo_fix = r_quo;
         end
         if (r_r_neg) begin
            w_rem_fix = ~r_rem + ONE;
         end else begin
            w_rem_fix = r_rem;
         end
      end
   end
`else
   logic w_unused_mode;
   assign w_unused_mode = is_signed;

   // Unsigned build: operands are already magnitudes.
   always_comb begin
      w_dvd_mag = dividend;
      w_dvs_mag = divisor;
   end

   // FIX copies results unchanged so latency matches the signed build.
   always_comb begin
      if (r_dvs_zero) begin
         w_quo_fix = ALL_ONES;
         w_rem_fix = r_dvd_orig;
      end else begin
         w_quo_fix = r_quo;
         w_rem_fix = r_rem;
      end
   end
`endif

   // One restoring step: shift rem:quo, trial-subtract; the extra bit carries the borrow.
   always_comb begin
      w_shift = {r_rem, r_quo[WIDTH-1]};
      w_trial = w_shift - {1'b0, r_dvs_mag};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state; abort returns to IDLE from any busy state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_CALC;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CALC: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (r_count == CW'(1)) begin
               w_next = S_FIX;
            end else begin
               w_next = S_CALC;
            end
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM control outputs.
   always_comb begin
      w_load = 1'b0;
      w_step = 1'b0;
      w_fix  = 1'b0;
      case (r_state)
         S_IDLE:  w_load = start;
         S_CALC:  w_step = ~abort;
         S_FIX:   w_fix  = ~abort;
         default: w_load = 1'b0;
      endcase
   end

   // Datapath: operand capture, iteration, and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count     <= {CW{1'b0}};
         r_rem       <= {WIDTH{1'b0}};
         r_quo       <= {WIDTH{1'b0}};
         r_dvs_mag   <= {WIDTH{1'b0}};
         r_dvd_orig  <= {WIDTH{1'b0}};
         r_dvs_zero  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= {WIDTH{1'b0}};
         r_remainder <= {WIDTH{1'b0}};
         r_div_zero  <= 1'b0;
      end else begin
         if (w_load) begin
            r_count    <= CW'(WIDTH);
            r_rem      <= {WIDTH{1'b0}};
            r_quo      <= w_dvd_mag;
            r_dvs_mag  <= w_dvs_mag;
            r_dvd_orig <= dividend;
            r_dvs_zero <= (divisor == {WIDTH{1'b0}});
         end else if (w_step) begin
            r_count <= r_count - CW'(1);
            if (w_trial[WIDTH]) begin
               r_rem <= w_shift[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end else begin
               r_rem <= w_trial[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end
         end
         if (w_fix) begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
            r_div_zero  <= r_dvs_zero;
         end
         r_done <= w_fix;
         r_busy <= (w_next != S_IDLE);
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: WIDTH=32 and WIDTH=8 instances, directed vectors.
module tb_hilo_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        s32_start, s32_abort, s32_signed;
   logic [31:0] s32_a, s32_b;
   logic        b32, d32, z32;
   logic [31:0] q32, r32;
   logic        s8_start, s8_abort, s8_signed;
   logic [7:0]  s8_a, s8_b;
   logic        b8, d8, z8;
   logic [7:0]  q8, r8;

   hilo_divider #(.WIDTH(32)) u_div32 (
      .clk(clk), .reset(reset), .start(s32_start), .abort(s32_abort),
      .is_signed(s32_signed), .dividend(s32_a), .divisor(s32_b),
      .busy(b32), .done(d32), .quotient(q32), .remainder(r32), .div_zero(z32));

   hilo_divider #(.WIDTH(8)) u_div8 (
      .clk(clk), .reset(reset), .start(s8_start), .abort(s8_abort),
      .is_signed(s8_signed), .dividend(s8_a), .divisor(s8_b),
      .busy(b8), .done(d8), .quotient(q8), .remainder(r8), .div_zero(z8));

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic        z;
      int          cyc;
   } exp_t;

   exp_t sb32[$];
   exp_t sb8[$];
   exp_t e32, e8;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Monitor for the 32-bit divider
   always @(negedge clk) begin
      if (d32) begin
         if (sb32.size() == 0) begin
            chk("done32_unexpected", 64'd1, 64'd0);
         end else begin
            e32 = sb32.pop_front();
            chk("quo32", q32, e32.q);
            chk("rem32", r32, e32.r);
            chk("dz32", z32, e32.z);
            chk("lat32", cyc, e32.cyc);
            chk("busy32_at_done", b32, 64'd0);
         end
      end
   end

   // Monitor for the 8-bit divider
   always @(negedge clk) begin
      if (d8) begin
         if (sb8.size() == 0) begin
            chk("done8_unexpected", 64'd1, 64'd0);
         end else begin
            e8 = sb8.pop_front();
            chk("quo8", q8, e8.q);
            chk("rem8", r8, e8.r);
            chk("dz8", z8, e8.z);
            chk("lat8", cyc, e8.cyc);
         end
      end
   end

   task automatic wait_done32();
      bit seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!seen) begin
            @(negedge clk);
            seen = d32;
         end
      end
      if (!seen) chk("timeout32", 64'd0, 64'd1);
   endtask

   task automatic wait_done8();
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!seen) begin
            @(negedge clk);
            seen = d8;
         end
      end
      if (!seen) chk("timeout8", 64'd0, 64'd1);
   endtask

   // Caller is at a negedge; returns at the negedge where done is high (back-to-back friendly).
   task automatic div32(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez);
      s32_start = 1'b1; s32_signed = s; s32_a = a; s32_b = b;
      @(posedge clk); #1;
      sb32.push_back('{eq, er, ez, cyc + 33});
      s32_start = 1'b0; s32_signed = ~s; s32_a = ~a; s32_b = b ^ 32'h5A5A_0F0F;
      wait_done32();
   endtask

   task automatic div8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez);
      s8_start = 1'b1; s8_signed = s; s8_a = a; s8_b = b;
      @(posedge clk); #1;
      sb8.push_back('{eq, er, ez, cyc + 9});
      s8_start = 1'b0; s8_signed = ~s; s8_a = ~a; s8_b = b ^ 8'h3C;
      wait_done8();
   endtask

   int c0;

   initial begin
      reset = 1'b1;
      s32_start = 1'b0; s32_abort = 1'b0; s32_signed = 1'b0; s32_a = 32'd0; s32_b = 32'd0;
      s8_start = 1'b0; s8_abort = 1'b0; s8_signed = 1'b0; s8_a = 8'd0; s8_b = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", b32, 64'd0);
      chk("rst_done", d32, 64'd0);
      chk("rst_quo", q32, 64'd0);
      chk("rst_rem", r32, 64'd0);
      chk("rst_dz", z32, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      div32(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      div32(1'b0, 32'hE8BA_0CDE, 32'hFFFF_EDCA, 32'h0, 32'hE8BA_0CDE, 1'b0);
      div32(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
`ifdef DIV_SIGNED_EN
      div32(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      div32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
`else
      div32(1'b1, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0);
      div32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
`endif
      div32(1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
      div32(1'b1, 32'hFFFF_FF9C, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
      div32(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

      // Abort mid-CALC: no done, outputs keep the 50/5 result
      @(negedge clk);
      s32_start = 1'b1; s32_a = 32'd1000; s32_b = 32'd3;
      @(posedge clk); #1;
      s32_start = 1'b0;
      chk("busy_after_start", b32, 64'd1);
      repeat (4) @(negedge clk);
      s32_start = 1'b1; s32_a = 32'd9; s32_b = 32'd9;
      @(negedge clk);
      s32_start = 1'b0;
      repeat (3) @(negedge clk);
      s32_abort = 1'b1;
      @(posedge clk); #1;
      s32_abort = 1'b0;
      chk("abort_busy", b32, 64'd0);
      chk("abort_done", d32, 64'd0);
      repeat (40) @(negedge clk);
      chk("abort_quo_hold", q32, 64'd10);
      chk("abort_rem_hold", r32, 64'd0);
      chk("abort_dz_hold", z32, 64'd0);

      // start+abort together in IDLE starts; a start at cycle 12 is ignored
      s32_start = 1'b1; s32_abort = 1'b1; s32_a = 32'd200; s32_b = 32'd9;
      @(posedge clk); #1;
      c0 = cyc;
      sb32.push_back('{64'd22, 64'd2, 1'b0, c0 + 33});
      s32_start = 1'b0; s32_abort = 1'b0;
      repeat (11) @(negedge clk);
      s32_start = 1'b1; s32_a = 32'd7; s32_b = 32'd7;
      @(negedge clk);
      s32_start = 1'b0;
      wait_done32();

      // Reset mid-CALC clears outputs without a clock edge
      s32_start = 1'b1; s32_a = 32'd1000; s32_b = 32'd3;
      @(posedge clk); #1;
      s32_start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", b32, 64'd0);
      chk("midrst_done", d32, 64'd0);
      chk("midrst_quo", q32, 64'd0);
      chk("midrst_rem", r32, 64'd0);
      chk("midrst_dz", z32, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("midrst_still_idle", b32, 64'd0);

      div8(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
`ifdef DIV_SIGNED_EN
      div8(1'b1, 8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0);
      div8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
`else
      div8(1'b1, 8'hFF, 8'h02, 8'h7F, 8'h01, 1'b0);
      div8(1'b1, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
`endif
      div8(1'b0, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1);
      div8(1'b0, 8'd17, 8'd17, 8'd1, 8'd0, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb32.size() + sb8.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
